serial_bit_source: RTL and testbench

Upstream feeder for the consecutive-ones detector: accepts parallel words over a valid/ready handshake and shifts them out one bit per clock on `x`, which drives the detector's serial input directly. An optional guard gap of zero bits after each word keeps a run of ones from spanning two words. While idle it holds `x` low, so it never produces false detections.

---
 rtl/serial_src_pkg.sv | 22 ++
 rtl/serial_bit_source.sv | 157 +++++++++++++++
 tb/tb_serial_bit_source.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_src_pkg.sv
// serial_src_pkg
//
// Shared definitions for the serial bit source that feeds the consecutive-ones
// detector: the three-state machine encoding and the default word geometry.
//
// Contents:
//   src_state_e        - IDLE / SHIFT / GAP
//   SRC_WIDTH_DEFAULT  - default bits per word
//   SRC_GAP_DEFAULT    - default number of zero-bit guard cycles after a word

package serial_src_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } src_state_e;

  localparam int SRC_WIDTH_DEFAULT = 8;
  localparam int SRC_GAP_DEFAULT   = 1;

endpackage

// File: rtl/serial_bit_source.sv
// serial_bit_source
//
// Accepts parallel words over a valid/ready handshake and shifts them out one
// bit per clock on x. After each word it can insert GAP_CYCLES zero bits so
// that a run of ones never spans two words. While idle x is held low.
//
// Parameters:
//   WIDTH       - bits per word (>= 2)
//   GAP_CYCLES  - zero-bit cycles after each word (0 allows back-to-back words)
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   asynchronous active-high reset
//   load_valid  in   data_in holds a word to send
//   data_in     in   word to serialize [WIDTH-1:0]
//   load_ready  out  a word can be accepted this cycle
//   x           out  serial data bit, 0 when not shifting
//   x_valid     out  x carries a data bit
//   busy        out  state is SHIFT or GAP
//   done        out  one-cycle pulse on the last data bit of a word
//
// Build option:
//   SERIAL_LSB_FIRST_EN - when defined, bit 0 is sent first and the register
//                         shifts right; otherwise MSB first, shifting left.

module serial_bit_source
  import serial_src_pkg::*;
#(
  parameter int WIDTH      = SRC_WIDTH_DEFAULT,
  parameter int GAP_CYCLES = SRC_GAP_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] data_in,
  output logic             load_ready,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  // The counter must hold both the bit index (WIDTH-1) and the gap length
  // (GAP_CYCLES-1), so it is sized for whichever is larger.
  localparam int CNT_MAX = (WIDTH > GAP_CYCLES + 1) ? WIDTH : GAP_CYCLES + 1;
  localparam int CW      = $clog2(CNT_MAX);

  localparam logic [CW-1:0] BIT_LOAD = CW'(WIDTH - 1);
  localparam logic [CW-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  src_state_e       r_state;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_cnt;
  logic             r_x;
  logic             r_xValid;
  logic             r_done;

  logic             w_lastBit;
  logic             w_loadReady;
  logic             w_accept;
  logic             w_firstBit;
  logic [WIDTH-1:0] w_loadRest;
  logic             w_headBit;
  logic [WIDTH-1:0] w_shifted;

  // The first bit of a word goes straight into the x register on the
  // handshake edge, so the shift register only keeps the bits still to come.
  // That is what makes the first bit appear in the cycle right after the
  // handshake.
  always_comb begin
    w_lastBit   = (r_state == SHIFT) && (r_cnt == '0);
    w_loadReady = (r_state == IDLE) || ((GAP_CYCLES == 0) && w_lastBit);
    w_accept    = load_valid && w_loadReady;
`ifdef SERIAL_LSB_FIRST_EN
    w_firstBit  = data_in[0];
    w_loadRest  = data_in >> 1;
    w_headBit   = r_shift[0];
    w_shifted   = r_shift >> 1;
`else
    w_firstBit  = data_in[WIDTH-1];
    w_loadRest  = data_in << 1;
    w_headBit   = r_shift[WIDTH-1];
    w_shifted   = r_shift << 1;
`endif
  end

  // Single state machine carrying the shift register, the shared down-counter
  // and the registered outputs. The counter is only ever reloaded at zero,
  // never decremented past it. done is raised on the edge that presents the
  // last bit, so it lines up with that bit on x.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_shift  <= '0;
      r_cnt    <= '0;
      r_x      <= 1'b0;
      r_xValid <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state  <= SHIFT;
            r_shift  <= w_loadRest;
            r_cnt    <= BIT_LOAD;
            r_x      <= w_firstBit;
            r_xValid <= 1'b1;
          end
        end
        SHIFT: begin
          if (r_cnt != '0) begin
            r_x     <= w_headBit;
            r_shift <= w_shifted;
            r_cnt   <= r_cnt - CNT_ONE;
            r_done  <= (r_cnt == CNT_ONE);
          end else if (GAP_CYCLES > 0) begin
            r_state  <= GAP;
            r_cnt    <= GAP_LOAD;
            r_x      <= 1'b0;
            r_xValid <= 1'b0;
          end else if (w_accept) begin
            // Back-to-back word: the next word's first bit follows directly.
            r_shift  <= w_loadRest;
            r_cnt    <= BIT_LOAD;
            r_x      <= w_firstBit;
            r_xValid <= 1'b1;
          end else begin
            r_state  <= IDLE;
            r_x      <= 1'b0;
            r_xValid <= 1'b0;
          end
        end
        GAP: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_ONE;
          end else begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_x      <= 1'b0;
          r_xValid <= 1'b0;
        end
      endcase
    end
  end

  assign load_ready = w_loadReady;
  assign x          = r_x;
  assign x_valid    = r_xValid;
  assign done       = r_done;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_serial_bit_source.sv
// tb_serial_bit_source
//
// Drives three serial_bit_source instances sharing one clock and reset:
//   u0: GAP_CYCLES=1, u1: GAP_CYCLES=0, u2: GAP_CYCLES=2 (WIDTH=8 for all).
// Each instance is compared every cycle against a word-level reference model
// that tracks only "which bit of which word is on the wire right now", plus a
// few directed scenarios and random traffic.
// Honors SERIAL_LSB_FIRST_EN for the expected bit order.

module tb_serial_bit_source;

  localparam int W = 8;

  logic       clk;
  logic       rst;
  logic       lv    [3];
  logic [7:0] din   [3];
  logic       ready [3];
  logic       xo    [3];
  logic       xv    [3];
  logic       bsy   [3];
  logic       dn    [3];

  int         nChecks;
  int         nErrors;

  // Reference model state: phase = -1 idle, 0..W-1 data bit index,
  // W..W+gap-1 guard cycles.
  int         phase [3];
  logic [7:0] word  [3];
  logic       acc   [3];

  serial_bit_source #(.WIDTH(W), .GAP_CYCLES(1)) u0 (
    .clk(clk), .rst(rst), .load_valid(lv[0]), .data_in(din[0]),
    .load_ready(ready[0]), .x(xo[0]), .x_valid(xv[0]), .busy(bsy[0]), .done(dn[0]));

  serial_bit_source #(.WIDTH(W), .GAP_CYCLES(0)) u1 (
    .clk(clk), .rst(rst), .load_valid(lv[1]), .data_in(din[1]),
    .load_ready(ready[1]), .x(xo[1]), .x_valid(xv[1]), .busy(bsy[1]), .done(dn[1]));

  serial_bit_source #(.WIDTH(W), .GAP_CYCLES(2)) u2 (
    .clk(clk), .rst(rst), .load_valid(lv[2]), .data_in(din[2]),
    .load_ready(ready[2]), .x(xo[2]), .x_valid(xv[2]), .busy(bsy[2]), .done(dn[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int gapOf(input int i);
    case (i)
      0: return 1;
      1: return 0;
      default: return 2;
    endcase
  endfunction

  // Bit k (in transmission order) of a word.
  function automatic logic expBit(input logic [7:0] w, input int k);
`ifdef SERIAL_LSB_FIRST_EN
    return w[k];
`else
    return w[W-1-k];
`endif
  endfunction

  function automatic logic modelReady(input int i);
    return (phase[i] < 0) || (gapOf(i) == 0 && phase[i] == W - 1);
  endfunction

  // Word-level model advanced on every clock edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        phase[i] <= -1;
        acc[i]   <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (lv[i] && modelReady(i)) begin
          word[i]  <= din[i];
          phase[i] <= 0;
          acc[i]   <= 1'b1;
        end else begin
          acc[i] <= 1'b0;
          if (phase[i] >= 0)
            phase[i] <= (phase[i] + 1 >= W + gapOf(i)) ? -1 : phase[i] + 1;
        end
      end
    end
  end

  // The one place that compares and counts.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic checkCycle();
    for (int i = 0; i < 3; i++) begin
      logic eValid;
      eValid = (phase[i] >= 0) && (phase[i] < W);
      checkOutput($sformatf("x_valid%0d", i), 32'(xv[i]), 32'(eValid));
      checkOutput($sformatf("x%0d", i), 32'(xo[i]), 32'(eValid ? expBit(word[i], phase[i]) : 1'b0));
      checkOutput($sformatf("done%0d", i), 32'(dn[i]), 32'(phase[i] == W - 1));
      checkOutput($sformatf("busy%0d", i), 32'(bsy[i]), 32'(phase[i] >= 0));
      checkOutput($sformatf("ready%0d", i), 32'(ready[i]), 32'(modelReady(i)));
    end
  endtask

  // Counters for the back-to-back scenario on u1.
  int  monValid;
  int  monOnes;
  int  monDone;

  task automatic tick();
    @(negedge clk);
    checkCycle();
    if (xv[1]) monValid++;
    if (xv[1] && xo[1]) monOnes++;
    if (dn[1]) monDone++;
  endtask

  // Offer a word on instance k and hold it until the model says it was taken.
  // Returns in the first data-bit cycle with load_valid still high.
  task automatic applyStimulus(input int k, input logic [7:0] w);
    bit got;
    got   = 1'b0;
    lv[k]  = 1'b1;
    din[k] = w;
    for (int c = 0; c < 40 && !got; c++) begin
      tick();
      if (acc[k]) got = 1'b1;
    end
    checkOutput($sformatf("accept%0d", k), 32'(got), 32'd1);
  endtask

  initial begin
    logic [7:0] seq;
    logic [7:0] e5Order;

    nChecks  = 0;
    nErrors  = 0;
    monValid = 0;
    monOnes  = 0;
    monDone  = 0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      lv[i]  = 1'b0;
      din[i] = 8'h00;
    end

    repeat (3) tick();
    checkOutput("rst_ready0", 32'(ready[0]), 32'd1);
    checkOutput("rst_busy0", 32'(bsy[0]), 32'd0);
    rst = 1'b0;
    repeat (2) tick();

    // 8'hE5 on the GAP=1 instance, bits read straight off the wire.
`ifdef SERIAL_LSB_FIRST_EN
    e5Order = 8'b10100111;
`else
    e5Order = 8'b11100101;
`endif
    applyStimulus(0, 8'hE5);
    lv[0] = 1'b0;
    seq = {7'b0, xo[0]};
    for (int b = 1; b < 8; b++) begin
      tick();
      seq = {seq[6:0], xo[0]};
    end
    checkOutput("e5_done_last", 32'(dn[0]), 32'd1);
    checkOutput("e5_sequence", 32'(seq), 32'(e5Order));
    tick();
    checkOutput("e5_gap_x", 32'(xo[0]), 32'd0);
    checkOutput("e5_gap_ready", 32'(ready[0]), 32'd0);
    tick();
    checkOutput("e5_ready_again", 32'(ready[0]), 32'd1);

    // GAP=0, load_valid held: FF then 00 back-to-back.
    monValid = 0;
    monOnes  = 0;
    monDone  = 0;
    applyStimulus(1, 8'hFF);
    applyStimulus(1, 8'h00);
    lv[1] = 1'b0;
    repeat (10) tick();
    checkOutput("b2b_valid_cycles", 32'(monValid), 32'd16);
    checkOutput("b2b_ones", 32'(monOnes), 32'd8);
    checkOutput("b2b_done_count", 32'(monDone), 32'd2);

    // GAP=2, 8'h07 then 8'hE0.
    applyStimulus(2, 8'h07);
    lv[2] = 1'b0;
    applyStimulus(2, 8'hE0);
    lv[2] = 1'b0;
    repeat (14) tick();

    // Reset while the 4th bit of 8'hFF is on the wire.
    applyStimulus(0, 8'hFF);
    lv[0] = 1'b0;
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_async_x", 32'(xo[0]), 32'd0);
    checkOutput("rst_async_xv", 32'(xv[0]), 32'd0);
    checkCycle();
    tick();
    rst = 1'b0;
    tick();
    checkOutput("post_rst_ready", 32'(ready[0]), 32'd1);
    applyStimulus(0, 8'h81);
    lv[0] = 1'b0;
    checkOutput("post_rst_first_bit", 32'(xo[0]), 32'd1);

    // 8'hAA pulsed during SHIFT must be ignored.
    repeat (2) tick();
    lv[0]  = 1'b1;
    din[0] = 8'hAA;
    tick();
    lv[0] = 1'b0;
    checkOutput("aa_ignored", 32'(acc[0]), 32'd0);
    repeat (12) tick();

    // Random traffic, including offers that change while not ready.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 3; i++) begin
        lv[i]  = ($urandom_range(0, 2) != 0);
        din[i] = 8'($urandom);
      end
      tick();
    end
    for (int i = 0; i < 3; i++) lv[i] = 1'b0;
    repeat (12) tick();

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
